// File: rtl/alu_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_pkg
// Brief    : Shared opcode/funct3 constants and the reservation-station entry.
// Revision : 1.0 - initial release
// ============================================================================
package alu_rs_pkg;

  localparam logic [6:0] OP_CALC     = 7'b0110011;
  localparam logic [6:0] OP_CALC_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Entry fields are sized for the widest supported build; narrower
  // instances keep the upper bits at zero.
  localparam int RS_XLEN_MAX  = 64;
  localparam int RS_TAG_W_MAX = 16;

  typedef struct packed {
    logic                    valid;
    logic [RS_TAG_W_MAX-1:0] tag;
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic                    flag;
    logic [RS_XLEN_MAX-1:0]  v1;
    logic                    r1;
    logic [RS_TAG_W_MAX-1:0] q1;
    logic [RS_XLEN_MAX-1:0]  v2;
    logic                    r2;
    logic [RS_TAG_W_MAX-1:0] q2;
  } rs_entry_t;

  function automatic logic is_alu_op(input logic [6:0] op);
    return (op == OP_CALC) || (op == OP_CALC_IMM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_exec
// Brief    : Combinational integer ALU for OP / OP-IMM instructions.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs_exec
  import alu_rs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            flag,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] w_shamt;
  assign w_shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (funct3)
      // OP-IMM has no SUBI, so the flag only selects subtract for OP
      F3_ADD:  result = (flag && (opcode == OP_CALC)) ? (a - b) : (a + b);
      F3_SLL:  result = a << w_shamt;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      F3_XOR:  result = a ^ b;
      F3_SR:   result = flag ? XLEN'($signed(a) >>> w_shamt) : (a >> w_shamt);
      F3_OR:   result = a | b;
      F3_AND:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_rs_gen2.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_gen2
// Brief    : Integer-ALU reservation station with CDB wakeup, age-ordered
//            issue and a single-entry result register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs_gen2
  import alu_rs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int XLEN    = 32,
  parameter int NUM_CDB = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [6:0]                   disp_opcode,
  input  logic [2:0]                   disp_funct3,
  input  logic                         disp_flag,
  input  logic [TAG_W-1:0]             disp_tag,
  input  logic [XLEN-1:0]              disp_v1,
  input  logic [XLEN-1:0]              disp_v2,
  input  logic [TAG_W-1:0]             disp_q1,
  input  logic [TAG_W-1:0]             disp_q2,
  input  logic                         disp_r1,
  input  logic                         disp_r2,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [TAG_W-1:0]             res_tag,
  output logic [XLEN-1:0]              res_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t                   r_ent [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] r_older;  // r_older[i][j]: entry i is older than j
  logic                        r_res_valid;
  logic [TAG_W-1:0]            r_res_tag;
  logic [XLEN-1:0]             r_res_data;

  logic [DEPTH-1:0]            w_valid, w_rdy, w_sel;
  logic [XLEN:0]               w_lk1 [DEPTH];
  logic [XLEN:0]               w_lk2 [DEPTH];
  logic [XLEN:0]               w_byp1, w_byp2;
  logic [IDX_W-1:0]            w_sel_idx, w_alloc_idx;
  logic [DEPTH-1:0][DEPTH-1:0] w_older_nxt;
  logic [OCC_W-1:0]            w_occ;
  logic [XLEN-1:0]             w_exec_res;
  logic                        w_issue, w_alloc;
  rs_entry_t                   w_new;

  // Returns {hit, data}; the lowest matching port wins.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_W-1:0]         q,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*TAG_W-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]  data
  );
    logic [XLEN:0] res;
    res = '0;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == q)) res = {1'b1, data[k*XLEN +: XLEN]};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_rdy[i]   = r_ent[i].valid && r_ent[i].r1 && r_ent[i].r2;
      w_lk1[i]   = cdb_lookup(r_ent[i].q1[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
      w_lk2[i]   = cdb_lookup(r_ent[i].q2[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_rdy[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && w_rdy[j] && !r_older[i][j]) w_sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_sel_idx   = '0;
    w_alloc_idx = '0;
    w_occ       = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (w_sel[i])    w_sel_idx   = IDX_W'(i);
      if (!w_valid[i]) w_alloc_idx = IDX_W'(i);
      w_occ = w_occ + OCC_W'(w_valid[i]);
    end
  end

  assign disp_ready = ~&w_valid;
  assign w_alloc    = disp_valid && disp_ready && is_alu_op(disp_opcode);
  assign w_issue    = (|w_sel) && (!r_res_valid || res_ready);
  assign w_byp1     = cdb_lookup(disp_q1, cdb_valid, cdb_tag, cdb_data);
  assign w_byp2     = cdb_lookup(disp_q2, cdb_valid, cdb_tag, cdb_data);

  always_comb begin
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.tag    = RS_TAG_W_MAX'(disp_tag);
    w_new.opcode = disp_opcode;
    w_new.funct3 = disp_funct3;
    w_new.flag   = disp_flag;
    w_new.r1     = disp_r1 || w_byp1[XLEN];
    w_new.r2     = disp_r2 || w_byp2[XLEN];
    w_new.v1     = RS_XLEN_MAX'((disp_r1 || !w_byp1[XLEN]) ? disp_v1 : w_byp1[XLEN-1:0]);
    w_new.v2     = RS_XLEN_MAX'((disp_r2 || !w_byp2[XLEN]) ? disp_v2 : w_byp2[XLEN-1:0]);
    w_new.q1     = RS_TAG_W_MAX'(disp_q1);
    w_new.q2     = RS_TAG_W_MAX'(disp_q2);
  end

  // A new entry is younger than every entry that survives this edge.
  always_comb begin
    w_older_nxt = r_older;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_issue && w_sel[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          w_older_nxt[i][j] = 1'b0;
          w_older_nxt[j][i] = 1'b0;
        end
      end
    end
    if (w_alloc) begin
      for (int j = 0; j < DEPTH; j++) begin
        w_older_nxt[w_alloc_idx][j] = 1'b0;
        w_older_nxt[j][w_alloc_idx] = w_valid[j] && !(w_issue && w_sel[j]);
      end
    end
  end

  alu_rs_exec #(.XLEN(XLEN)) u_exec (
    .opcode (r_ent[w_sel_idx].opcode),
    .funct3 (r_ent[w_sel_idx].funct3),
    .flag   (r_ent[w_sel_idx].flag),
    .a      (r_ent[w_sel_idx].v1[XLEN-1:0]),
    .b      (r_ent[w_sel_idx].v2[XLEN-1:0]),
    .result (w_exec_res)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_older <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_older <= '0;
    end else begin
      r_older <= w_older_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid && !r_ent[i].r1 && w_lk1[i][XLEN]) begin
          r_ent[i].v1 <= RS_XLEN_MAX'(w_lk1[i][XLEN-1:0]);
          r_ent[i].r1 <= 1'b1;
        end
        if (r_ent[i].valid && !r_ent[i].r2 && w_lk2[i][XLEN]) begin
          r_ent[i].v2 <= RS_XLEN_MAX'(w_lk2[i][XLEN-1:0]);
          r_ent[i].r2 <= 1'b1;
        end
        if (w_issue && w_sel[i]) r_ent[i].valid <= 1'b0;
        if (w_alloc && (w_alloc_idx == IDX_W'(i))) r_ent[i] <= w_new;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
      r_res_data  <= '0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
    end else if (w_issue) begin
      r_res_valid <= 1'b1;
      r_res_tag   <= r_ent[w_sel_idx].tag[TAG_W-1:0];
      r_res_data  <= w_exec_res;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_tag   = r_res_tag;
  assign res_data  = r_res_data;
  assign occupancy = w_occ;

  // Upper entry bits are always zero in narrow builds; fold them into a sink.
  logic [DEPTH-1:0] w_unused_par;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unused
    assign w_unused_par[gi] = ^r_ent[gi];
  end

endmodule
`default_nettype wire
